// File: rtl/dadda_pkg.sv
// Shared widths and Dadda stage-height schedule for the 8x8 multiplier.
// dadda_cnt() derives per-column adder counts at elaboration time.
package dadda_pkg;

  localparam int OP_W    = 8;
  localparam int PROD_W  = 16;
  localparam int N_STAGE = 4;
  localparam int MAX_H   = 8;

  localparam int STAGE_H [N_STAGE] = '{6, 4, 3, 2};

  localparam int CNT_HEIGHT = 0;
  localparam int CNT_FA     = 1;
  localparam int CNT_HA     = 2;

  // kind: input height of (stage, col), or number of FAs / HAs placed there.
  // Carries from column c-1 count towards column c's height within the same stage.
  function automatic int dadda_cnt(input int stage, input int col, input int kind);
    int h  [PROD_W];
    int hn [PROD_W];
    int cin;
    int r;
    int nf;
    int nh;
    int res;
    res = 0;
    for (int c = 0; c < PROD_W; c++) begin
      if (c < OP_W)           h[c] = c + 1;
      else if (c < 2*OP_W-1)  h[c] = 2*OP_W - 1 - c;
      else                    h[c] = 0;
      hn[c] = 0;
    end
    for (int s = 0; s < N_STAGE; s++) begin
      cin = 0;
      for (int c = 0; c < PROD_W; c++) begin
        r  = h[c] + cin - STAGE_H[s];
        nf = (r > 0) ? r / 2 : 0;
        nh = (r > 0) ? r % 2 : 0;
        if (s == stage && c == col) begin
          if (kind == CNT_HEIGHT)  res = h[c];
          else if (kind == CNT_FA) res = nf;
          else                     res = nh;
        end
        hn[c] = h[c] - 2*nf - nh + cin;
        cin   = nf + nh;
      end
      for (int c = 0; c < PROD_W; c++) h[c] = hn[c];
    end
    if (stage >= N_STAGE && kind == CNT_HEIGHT) res = h[col];
    return res;
  endfunction

endpackage

// File: rtl/dadda_fa.sv
// One-bit full adder; used as a half adder with cin tied low.
module dadda_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/dadda_mul.sv
// Unsigned 8x8 Dadda multiplier with registered product (latency 1).
// Define DADDA_IN_REG_EN to also register A/B/in_valid (latency 2).
module dadda_mul
  import dadda_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic              out_valid,
  output logic [PROD_W-1:0] Result
);

  logic [OP_W-1:0] a_t;
  logic [OP_W-1:0] b_t;
  logic            v_t;

`ifdef DADDA_IN_REG_EN
  logic [OP_W-1:0] a_q, a_d;
  logic [OP_W-1:0] b_q, b_d;
  logic            v_q, v_d;

  always_comb begin
    a_d = A;
    b_d = B;
    v_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      v_q <= v_d;
    end
  end

  assign a_t = a_q;
  assign b_t = b_q;
  assign v_t = v_q;
`else
  assign a_t = A;
  assign b_t = B;
  assign v_t = in_valid;
`endif

  // stg[s][col][k]: bit k of column col entering stage s; stg[N_STAGE] feeds the CPA.
  wire [PROD_W-1:0][MAX_H-1:0] stg [0:N_STAGE];
  wire [PROD_W-1:0][MAX_H-1:0] cry [0:N_STAGE-1];

  for (genvar i = 0; i < OP_W; i++) begin : g_pp_row
    for (genvar j = 0; j < OP_W; j++) begin : g_pp_col
      localparam int COL = i + j;
      localparam int LO  = (COL > OP_W - 1) ? COL - (OP_W - 1) : 0;
      assign stg[0][COL][i - LO] = a_t[j] & b_t[i];
    end
  end

  for (genvar c = 0; c < PROD_W; c++) begin : g_pp_pad
    localparam int H0 = dadda_cnt(0, c, CNT_HEIGHT);
    for (genvar z = H0; z < MAX_H; z++) begin : g_zero
      assign stg[0][c][z] = 1'b0;
    end
  end

  // Output column layout: FA sums, HA sums, untouched bits, then carries from col-1.
  for (genvar s = 0; s < N_STAGE; s++) begin : g_stage
    for (genvar c = 0; c < PROD_W; c++) begin : g_col
      localparam int HI  = dadda_cnt(s, c, CNT_HEIGHT);
      localparam int NF  = dadda_cnt(s, c, CNT_FA);
      localparam int NH  = dadda_cnt(s, c, CNT_HA);
      localparam int NP  = HI - 3*NF - 2*NH;
      localparam int CB  = HI - 2*NF - NH;
      localparam int NCP = (c == 0) ? 0 :
                           dadda_cnt(s, c - 1, CNT_FA) + dadda_cnt(s, c - 1, CNT_HA);

      for (genvar f = 0; f < NF; f++) begin : g_fa
        dadda_fa u_fa (
          .a    (stg[s][c][3*f]),
          .b    (stg[s][c][3*f+1]),
          .cin  (stg[s][c][3*f+2]),
          .s    (stg[s+1][c][f]),
          .cout (cry[s][c][f])
        );
      end

      for (genvar h = 0; h < NH; h++) begin : g_ha
        dadda_fa u_ha (
          .a    (stg[s][c][3*NF+2*h]),
          .b    (stg[s][c][3*NF+2*h+1]),
          .cin  (1'b0),
          .s    (stg[s+1][c][NF+h]),
          .cout (cry[s][c][NF+h])
        );
      end

      for (genvar p = 0; p < NP; p++) begin : g_pass
        assign stg[s+1][c][NF+NH+p] = stg[s][c][3*NF+2*NH+p];
      end

      if (c > 0) begin : g_cin
        for (genvar k = 0; k < NCP; k++) begin : g_k
          assign stg[s+1][c][CB+k] = cry[s][c-1][k];
        end
      end

      for (genvar z = CB + NCP; z < MAX_H; z++) begin : g_zero
        assign stg[s+1][c][z] = 1'b0;
      end

      for (genvar z = NF + NH; z < MAX_H; z++) begin : g_cry_zero
        assign cry[s][c][z] = 1'b0;
      end
    end
  end

  wire [PROD_W-1:0] row_a;
  wire [PROD_W-1:0] row_b;

  for (genvar c = 0; c < PROD_W; c++) begin : g_rows
    assign row_a[c] = stg[N_STAGE][c][0];
    assign row_b[c] = stg[N_STAGE][c][1];
  end

  // The carry out of column 14 lands in bit 15; the product never exceeds 16 bits.
  logic [PROD_W-1:0] prod;
  assign prod = row_a + row_b;

  // Padding bits and the top column's carries are structurally present but unused.
  logic unused_bits;
  assign unused_bits = ^{stg[0], stg[1], stg[2], stg[3], stg[4],
                         cry[0], cry[1], cry[2], cry[3]};

  logic [PROD_W-1:0] result_q, result_d;
  logic              out_valid_q, out_valid_d;

  always_comb begin
    result_d    = result_q;
    out_valid_d = 1'b0;
    if (v_t) begin
      result_d    = prod;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dadda_mul.sv
// Scoreboard bench for dadda_mul: driver pushes per-edge expectations,
// monitor pops and compares after every rising edge.
module tb_dadda_mul;

`ifdef DADDA_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  A = 8'h00;
  logic [7:0]  B = 8'h00;
  logic        out_valid;
  logic [15:0] Result;

  always #5 clk = ~clk;

  dadda_mul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .Result    (Result)
  );

  typedef struct packed {
    logic        v;
    logic [15:0] r;
  } exp_t;

  exp_t        exp_q[$];
  bit          h_rst [4096];
  bit          h_v   [4096];
  int unsigned h_p   [4096];
  int          edge_n = 0;
  int unsigned model_res = 0;
  int          tests = 0;
  int          fails = 0;
  bit          done = 0;

  // Expected output after edge n: a reset anywhere in the last LAT edges clears
  // everything; otherwise the operands issued LAT-1 edges earlier decide.
  task automatic step(input bit r, input bit v, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    bit   any_rst;
    int   src;
    @(negedge clk);
    rst = r; in_valid = v; A = a; B = b;
    h_rst[edge_n] = r;
    h_v[edge_n]   = v;
    h_p[edge_n]   = v ? (int'(a) * int'(b)) : 0;
    any_rst = 1'b0;
    for (int k = 0; k < LAT; k++)
      if (edge_n - k < 0 || h_rst[edge_n - k]) any_rst = 1'b1;
    src = edge_n - LAT + 1;
    if (any_rst) begin
      model_res = 0;
      e.v = 1'b0;
    end else if (h_v[src]) begin
      model_res = h_p[src];
      e.v = 1'b1;
    end else begin
      e.v = 1'b0;
    end
    e.r = model_res[15:0];
    exp_q.push_back(e);
    edge_n++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tests++;
        if (out_valid !== e.v) begin
          fails++;
          $display("FAIL out_valid edge=%0d got=%b want=%b", edge_n, out_valid, e.v);
        end
        tests++;
        if (Result !== e.r) begin
          fails++;
          $display("FAIL result edge=%0d got=%0d want=%0d", edge_n, Result, e.r);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    if (!done) begin
      $display("FAIL watchdog timeout tests=%0d", tests);
      $fatal(1, "watchdog");
    end
  end

  initial begin : driver
    logic [7:0] ra, rb;
    bit         rv, rr;
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b0, 1'b1, 8'd255, 8'd255);
    step(1'b0, 1'b1, 8'd0,   8'd173);
    step(1'b0, 1'b1, 8'd1,   8'd173);
    step(1'b0, 1'b1, 8'd128, 8'd2);
    step(1'b0, 1'b1, 8'd15,  8'd17);
    step(1'b0, 1'b1, 8'd200, 8'd100);
    step(1'b0, 1'b0, 8'd3,   8'd3);
    step(1'b0, 1'b0, 8'bx,   8'bx);
    step(1'b0, 1'b0, 8'd9,   8'd9);
    step(1'b0, 1'b1, 8'd255, 8'd1);
    step(1'b0, 1'b1, 8'd1,   8'd255);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rv = ($urandom_range(0, 7) != 0);
      rr = (i == 400) || (i == 700) || (i == 701);
      step(rr, rv, ra, rb);
    end

    for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b0, 8'd0, 8'd0);

    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain leftover=%0d want=0", exp_q.size());
    end
    done = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
